// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with big-endian load alignment and retire counter.
// Optional LWL/LWR merge with the old rt value is enabled by UNALIGNED_LOAD_EN.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              flush,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [2:0]        mem_load_op,
    input  logic [1:0]        mem_addr_lo,
    input  logic [DATA_W-1:0] mem_rt_data,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_wreg,
    output logic [ADDR_W-1:0] wb_wd,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_valid,
    output logic [31:0]       retire_cnt
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_LB   = 3'd1;
    localparam logic [2:0] OP_LBU  = 3'd2;
    localparam logic [2:0] OP_LH   = 3'd3;
    localparam logic [2:0] OP_LHU  = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_LWL  = 3'd6;
    localparam logic [2:0] OP_LWR  = 3'd7;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_ld_data;
    logic              w_wr_ok;

    logic              r_wreg;
    logic [ADDR_W-1:0] r_wd;
    logic [DATA_W-1:0] r_wdata;
    logic              r_valid;
    logic [31:0]       r_retire_cnt;

`ifndef UNALIGNED_LOAD_EN
    logic w_unused_rt;
    assign w_unused_rt = ^mem_rt_data;
`endif

    // Select the addressed byte and halfword (big-endian lanes).
    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (mem_addr_lo)
            2'd0: w_byte = dmem_rdata[31:24];
            2'd1: w_byte = dmem_rdata[23:16];
            2'd2: w_byte = dmem_rdata[15:8];
            default: w_byte = dmem_rdata[7:0];
        endcase
        w_half = mem_addr_lo[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
    end

    // Build the write-back value for the MEM instruction.
    always_comb begin
        w_ld_data = mem_wdata;
        w_wr_ok   = 1'b1;
        case (mem_load_op)
            OP_NONE: w_ld_data = mem_wdata;
            OP_LB:   w_ld_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_ld_data = {24'd0, w_byte};
            OP_LH:   w_ld_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_ld_data = {16'd0, w_half};
            OP_LW:   w_ld_data = dmem_rdata;
`ifdef UNALIGNED_LOAD_EN
            OP_LWL: begin
                case (mem_addr_lo)
                    2'd0: w_ld_data = dmem_rdata;
                    2'd1: w_ld_data = {dmem_rdata[23:0], mem_rt_data[7:0]};
                    2'd2: w_ld_data = {dmem_rdata[15:0], mem_rt_data[15:0]};
                    default: w_ld_data = {dmem_rdata[7:0], mem_rt_data[23:0]};
                endcase
            end
            OP_LWR: begin
                case (mem_addr_lo)
                    2'd0: w_ld_data = {mem_rt_data[31:8], dmem_rdata[31:24]};
                    2'd1: w_ld_data = {mem_rt_data[31:16], dmem_rdata[31:16]};
                    2'd2: w_ld_data = {mem_rt_data[31:24], dmem_rdata[31:8]};
                    default: w_ld_data = dmem_rdata;
                endcase
            end
`else
            OP_LWL, OP_LWR: begin
                w_ld_data = '0;
                w_wr_ok   = 1'b0;
            end
`endif
            default: w_ld_data = mem_wdata;
        endcase
    end

    // Pipeline register: reset, flush/bubble, hold, or capture.
    always_ff @(posedge clk) begin
        if (rst || flush || (stall_mem && !stall_wb)) begin
            r_wreg  <= 1'b0;
            r_wd    <= '0;
            r_wdata <= '0;
            r_valid <= 1'b0;
        end else if (!stall_mem) begin
            r_wreg  <= mem_wreg && (mem_wd != '0) && w_wr_ok;
            r_wd    <= mem_wd;
            r_wdata <= w_ld_data;
            r_valid <= 1'b1;
        end
    end

    // Count instructions that leave WB; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (r_valid && !stall_wb) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign wb_wreg    = r_wreg;
    assign wb_wd      = r_wd;
    assign wb_wdata   = r_wdata;
    assign wb_valid   = r_valid;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver queues expected WB state,
// monitor compares one record per cycle after each rising edge.
module tb_mem_wb_stage;

    typedef struct packed {
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_mem;
    logic        stall_wb;
    logic        flush;
    logic        mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_load_op;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_rt_data;
    logic [31:0] dmem_rdata;
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        wb_valid;
    logic [31:0] retire_cnt;

    exp_t  q[$];
    string qn[$];
    exp_t  last;
    exp_t  me;
    string mn;
    int    n_tests = 0;
    int    n_fail  = 0;

    mem_wb_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall_mem  (stall_mem),
        .stall_wb   (stall_wb),
        .flush      (flush),
        .mem_wreg   (mem_wreg),
        .mem_wd     (mem_wd),
        .mem_wdata  (mem_wdata),
        .mem_load_op(mem_load_op),
        .mem_addr_lo(mem_addr_lo),
        .mem_rt_data(mem_rt_data),
        .dmem_rdata (dmem_rdata),
        .wb_wreg    (wb_wreg),
        .wb_wd      (wb_wd),
        .wb_wdata   (wb_wdata),
        .wb_valid   (wb_valid),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: compare WB outputs against the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            mn = qn.pop_front();
            n_tests++;
            if (wb_wreg !== me.wreg || wb_wd !== me.wd ||
                wb_wdata !== me.wdata || wb_valid !== me.valid ||
                retire_cnt !== me.cnt) begin
                n_fail++;
                $display("FAIL %s: got wreg=%0b wd=%0d wdata=%h valid=%0b cnt=%h, want wreg=%0b wd=%0d wdata=%h valid=%0b cnt=%h",
                         mn, wb_wreg, wb_wd, wb_wdata, wb_valid, retire_cnt,
                         me.wreg, me.wd, me.wdata, me.valid, me.cnt);
            end
        end
    end

    // Drive one cycle of MEM inputs (called at negedge) and queue the
    // WB state expected after the next rising edge.
    task automatic step(input string nm, input logic r, input logic sm,
                        input logic sw, input logic fl, input logic wr,
                        input logic [4:0] wd, input logic [31:0] wdat,
                        input logic [2:0] op, input logic [1:0] alo,
                        input logic [31:0] rt, input logic [31:0] rd,
                        input logic e_wreg, input logic [31:0] e_wdata);
        exp_t e;
        rst = r; stall_mem = sm; stall_wb = sw; flush = fl;
        mem_wreg = wr; mem_wd = wd; mem_wdata = wdat;
        mem_load_op = op; mem_addr_lo = alo;
        mem_rt_data = rt; dmem_rdata = rd;
        e = '0;
        if (!r) begin
            e = last;
            e.cnt = (last.valid && !sw) ? last.cnt + 32'd1 : last.cnt;
            if (fl || (sm && !sw)) begin
                e.wreg = 1'b0; e.wd = '0; e.wdata = '0; e.valid = 1'b0;
            end else if (!sm) begin
                e.wreg = e_wreg; e.wd = wd; e.wdata = e_wdata;
                e.valid = 1'b1;
            end
        end
        last = e;
        q.push_back(e);
        qn.push_back(nm);
        @(negedge clk);
    endtask

    localparam logic [31:0] RD  = 32'h80F17F22;
    localparam logic [31:0] URD = 32'h11223344;
    localparam logic [31:0] URT = 32'hAABBCCDD;

    initial begin
        last = '0;
        @(negedge clk);
        step("rst0", 1,0,0,0, 1,5'd3,32'h1,0,0,0,0, 0,0);
        step("rst1", 1,0,0,0, 1,5'd3,32'h1,0,0,0,0, 0,0);
        step("alu",  0,0,0,0, 1,5'd5,32'h12345678,0,0,0,RD, 1,32'h12345678);
        step("lb1",  0,0,0,0, 1,5'd1,0,3'd1,2'd1,0,RD, 1,32'hFFFFFFF1);
        step("lbu1", 0,0,0,0, 1,5'd2,0,3'd2,2'd1,0,RD, 1,32'h000000F1);
        step("lh0",  0,0,0,0, 1,5'd3,0,3'd3,2'd0,0,RD, 1,32'hFFFF80F1);
        step("lhu2", 0,0,0,0, 1,5'd4,0,3'd4,2'd2,0,RD, 1,32'h00007F22);
        step("lhu3", 0,0,0,0, 1,5'd4,0,3'd4,2'd3,0,RD, 1,32'h00007F22);
        step("lw",   0,0,0,0, 1,5'd6,0,3'd5,2'd2,0,RD, 1,32'h80F17F22);
        step("lb3",  0,0,0,0, 1,5'd1,0,3'd1,2'd3,0,RD, 1,32'h00000022);
        step("lb0",  0,0,0,0, 1,5'd1,0,3'd1,2'd0,0,RD, 1,32'hFFFFFF80);
        step("cap7", 0,0,0,0, 1,5'd7,32'hCAFEF00D,0,0,0,0, 1,32'hCAFEF00D);
        step("hold1",0,1,1,0, 1,5'd9,32'h99,0,0,0,0, 0,0);
        step("hold2",0,1,1,0, 1,5'd9,32'h99,0,0,0,0, 0,0);
        step("hold3",0,1,1,0, 1,5'd9,32'h99,0,0,0,0, 0,0);
        step("bub",  0,1,0,0, 1,5'd9,32'h99,0,0,0,0, 0,0);
        step("cap8", 0,0,0,0, 1,5'd8,32'h00000808,0,0,0,0, 1,32'h00000808);
        step("flush",0,0,0,1, 1,5'd9,32'h99,0,0,0,0, 0,0);
        step("r0",   0,0,0,0, 1,5'd0,32'h55,0,0,0,0, 0,32'h55);
        step("nowr", 0,0,0,0, 0,5'd10,32'hABCD,0,0,0,0, 0,32'hABCD);
`ifdef UNALIGNED_LOAD_EN
        step("lwl1", 0,0,0,0, 1,5'd11,0,3'd6,2'd1,URT,URD, 1,32'h223344DD);
        step("lwr2", 0,0,0,0, 1,5'd12,0,3'd7,2'd2,URT,URD, 1,32'hAA112233);
`else
        step("lwl1", 0,0,0,0, 1,5'd11,0,3'd6,2'd1,URT,URD, 0,32'h0);
        step("lwr2", 0,0,0,0, 1,5'd12,0,3'd7,2'd2,URT,URD, 0,32'h0);
`endif
        step("cap13",0,0,0,0, 1,5'd13,32'h13,0,0,0,0, 1,32'h13);
        step("rsthld",1,1,1,0, 1,5'd14,32'h14,0,0,0,0, 0,0);
        step("cap15",0,0,0,0, 1,5'd15,32'h15,0,0,0,0, 1,32'h15);
        dut.r_retire_cnt = 32'hFFFFFFFF;
        last.cnt = 32'hFFFFFFFF;
        step("wrap", 0,0,0,0, 1,5'd16,32'h16,0,0,0,0, 1,32'h16);
        step("post", 0,0,0,0, 1,5'd17,32'h17,0,0,0,0, 1,32'h17);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
